pulse_freq_meter: RTL
=====================

# pulse_freq_meter

Receive-side counterpart to the waveform generator: takes the generated `Pulse` waveform back in, synchronizes it to `sysclk`, and measures it two ways. It reports the period in `sysclk` cycles between successive rising edges, and the number of rising edges per fixed gate window. It sits on the loopback/monitor path so the frequency selected by the Plus/Minus buttons can be checked in hardware and in simulation.

## Interface
Parameters:
- `GATE_CYCLES`, default 1_000_000: length of the frequency gate window in `sysclk` cycles (≥ 2).
- `PERIOD_W`, default 24: width of the period counter and the `Period` output.
- `COUNT_W`, default 16: width of the edge counter and the `Freq_Count` output.

Ports:
- `sysclk`, in, 1: the single clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `Pulse_In`, in, 1: asynchronous pulse waveform to be measured.
- `Period`, out, PERIOD_W: last measured rising-to-rising period, in cycles.
- `Period_Valid`, out, 1: one-cycle strobe when `Period` updates.
- `Freq_Count`, out, COUNT_W: rising edges counted in the last gate window.
- `Freq_Valid`, out, 1: one-cycle strobe when `Freq_Count` updates.
- `Stalled`, out, 1: the period counter saturated without seeing an edge.

## Operation
Synchronizer and edge detector:
- Two-flop synchronizer `s1`→`s2`, plus a history flop `prev`.
- `rise = s2 & ~prev`.
- All three flops reset to 0. A `Pulse_In` held high through reset therefore yields exactly one `rise` after release. This is required behaviour.

Period FSM, states WAIT_EDGE (reset state), COUNT and TIMEOUT:
- **WAIT_EDGE:** on `rise`, set `cnt`←1 and go to COUNT. No `Period_Valid` is issued.
- **COUNT:** `cnt` increments each cycle.
  - On `rise`: `Period`←`cnt`, pulse `Period_Valid`, `cnt`←1, clear `Stalled`.
  - If `cnt` = 2^PERIOD_W−1 and there is no `rise`: go to TIMEOUT, set `Stalled`←1 and `Period`←all ones. No `Period_Valid` is issued.
- **TIMEOUT:** `cnt` holds. On `rise`, set `cnt`←1 and go to COUNT. `Stalled` stays 1 until the next `Period_Valid`.
- Result: a waveform with a period of N cycles reports `Period` = N.

Gate counter (independent of the FSM):
- `gcnt` runs from 0 to GATE_CYCLES−1 and wraps.
- `edges` increments on `rise` and saturates at all ones.
- When `gcnt` = GATE_CYCLES−1:
  - `Freq_Count` ← `edges` plus the `rise` in that same cycle, saturated.
  - `edges` ← 0.
  - Pulse `Freq_Valid`.
- A `rise` on the terminal cycle is counted in the closing window, not the next one.

Reset:
- All outputs are 0 on reset: `Period`, `Period_Valid`, `Freq_Count`, `Freq_Valid`, `Stalled`.
- FSM returns to WAIT_EDGE; `cnt`, `gcnt` and `edges` return to 0.
- Reset asserted mid-measurement takes effect at the next clock edge and discards the partial measurement.

Limits:
- Minimum resolvable input is 1 cycle high and 1 cycle low, i.e. a period of 2.
- Narrower glitches may be missed. This is not an error.

## Timing
- `Pulse_In` rising, first sampled at edge k, gives `rise` high in the cycle after edge k+1. `Period_Valid` and the `Period` update are registered at edge k+2. End-to-end latency is 3 edges.
- `Period_Valid` and `Freq_Valid` are exactly one cycle wide and may coincide.
- `Period` and `Freq_Count` hold their values between strobes.
- The first `Freq_Valid` after reset is issued at the GATE_CYCLES-th clock edge after reset release.
- There is no backpressure. Consumers must sample the outputs on the strobe.

## Structure
- Shared package `freq_pkg`: FSM state encodings (WAIT_EDGE=2'd0, COUNT=2'd1, TIMEOUT=2'd2), and default `PERIOD_W`, `COUNT_W` and `GATE_CYCLES` constants.
- Sub-module `edge_sync`: 2-flop synchronizer plus rising-edge detect.
  - Ports: `sysclk`, `reset`, `d`, `rise`.
  - Reused for the debounced button paths.
- The top holds the FSM, period counter and gate counter.

## Test plan
- **Square wave, period 10:** after the first edge, every `Period_Valid` shows `Period`=10 and `Stalled`=0.
- **Gate windows:** `GATE_CYCLES`=100 with period 10 → `Freq_Valid` every 100 cycles and `Freq_Count`=10. An edge placed exactly on the terminal cycle is counted in the closing window.
- **Stall and recovery:** `PERIOD_W`=4, input stopped after 2 edges → `Stalled`=1 and `Period`=15 once 15 edge-free cycles elapse. Restart with period 6 → `Stalled` clears at the first `Period_Valid`, with `Period`=6.
- **Minimum period:** 1-high/1-low input → `Period`=2 on every strobe. `COUNT_W`=2 with 10 edges per window → `Freq_Count` saturates at 3.
- **Reset mid-count:** `reset`=0 for 1 cycle during COUNT → all outputs 0 next cycle. The first edge after release produces no `Period_Valid`; the second edge produces a correct `Period`.
- **Held-high input:** `Pulse_In`=1 through reset → exactly one `rise` after release, FSM in COUNT, then `Stalled` once `cnt` saturates.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared definitions for the pulse frequency meter: FSM state encoding and
// default widths / gate length used by the top-level parameters.
package freq_pkg;

  localparam int DEF_PERIOD_W    = 24;
  localparam int DEF_COUNT_W     = 16;
  localparam int DEF_GATE_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    COUNT     = 2'd1,
    TIMEOUT   = 2'd2
  } meter_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with a history flop and rising-edge detect.
// All flops clear on reset, so an input already high at release produces a
// single rise once it has crossed the synchronizer.
module edge_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  // Synchronize the asynchronous input and keep one cycle of history.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_prev;

endmodule

// File: rtl/pulse_freq_meter.sv
// Measures a looped-back pulse waveform two ways: rising-to-rising period in
// sysclk cycles, and rising edges per fixed gate window.
module pulse_freq_meter
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int PERIOD_W    = DEF_PERIOD_W,
  parameter int COUNT_W     = DEF_COUNT_W
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                Pulse_In,
  output logic [PERIOD_W-1:0] Period,
  output logic                Period_Valid,
  output logic [COUNT_W-1:0]  Freq_Count,
  output logic                Freq_Valid,
  output logic                Stalled
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  logic w_rise;

  edge_sync u_sync (
    .sysclk (sysclk),
    .reset  (reset),
    .d      (Pulse_In),
    .rise   (w_rise)
  );

  // ---------------------------------------------------------------- period
  meter_state_t        r_state;
  meter_state_t        w_state_nxt;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic [PERIOD_W-1:0] w_period_nxt;
  logic                w_pv_nxt;
  logic                w_stalled_nxt;

  // FSM state register.
  always_ff @(posedge sysclk) begin
    if (!reset) r_state <= WAIT_EDGE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus period counter / result updates. The counter starts at 1
  // on the edge so that the value seen on the following edge equals the
  // period; it stops at all ones and the FSM parks in TIMEOUT.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = Period;
    w_pv_nxt      = 1'b0;
    w_stalled_nxt = Stalled;
    case (r_state)
      WAIT_EDGE: begin
        if (w_rise) begin
          w_cnt_nxt   = PERIOD_W'(1);
          w_state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (w_rise) begin
          w_period_nxt  = r_cnt;
          w_pv_nxt      = 1'b1;
          w_cnt_nxt     = PERIOD_W'(1);
          w_stalled_nxt = 1'b0;
        end else if (r_cnt == '1) begin
          w_state_nxt   = TIMEOUT;
          w_stalled_nxt = 1'b1;
          w_period_nxt  = '1;
        end else begin
          w_cnt_nxt = r_cnt + PERIOD_W'(1);
        end
      end
      TIMEOUT: begin
        // Stalled is deliberately left set until a real measurement lands.
        if (w_rise) begin
          w_cnt_nxt   = PERIOD_W'(1);
          w_state_nxt = COUNT;
        end
      end
      default: w_state_nxt = WAIT_EDGE;
    endcase
  end

  // Period datapath registers.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_cnt        <= '0;
      Period       <= '0;
      Period_Valid <= 1'b0;
      Stalled      <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      Period       <= w_period_nxt;
      Period_Valid <= w_pv_nxt;
      Stalled      <= w_stalled_nxt;
    end
  end

  // ------------------------------------------------------------------ gate
  logic [GW-1:0]      r_gcnt;
  logic [COUNT_W-1:0] r_edges;
  logic [COUNT_W-1:0] w_edges_inc;
  logic               w_gate_end;

  assign w_gate_end  = (r_gcnt == GATE_LAST);
  // Saturating edge count including this cycle's rise, so a rise on the
  // terminal cycle is credited to the window that is closing.
  assign w_edges_inc = (w_rise && (r_edges != '1)) ? r_edges + COUNT_W'(1) : r_edges;

  // Gate window counter and per-window edge tally.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_gcnt     <= '0;
      r_edges    <= '0;
      Freq_Count <= '0;
      Freq_Valid <= 1'b0;
    end else if (w_gate_end) begin
      r_gcnt     <= '0;
      r_edges    <= '0;
      Freq_Count <= w_edges_inc;
      Freq_Valid <= 1'b1;
    end else begin
      r_gcnt     <= r_gcnt + GW'(1);
      r_edges    <= w_edges_inc;
      Freq_Valid <= 1'b0;
    end
  end

endmodule
